// File: rtl/sum_display_7seg_if.sv
// Operand/result bus from the adder and the multiplexed 7-segment drive lines.
// The display stage takes the slave side.
interface sum_display_7seg_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] sum;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (output a, b, sum, input seg, dp, an);
  modport slave  (input a, b, sum, output seg, dp, an);
endinterface

// File: rtl/sum_display_7seg.sv
// Shows A | B. | sum-tens | sum-ones on a 4-digit common-anode display.
// Each frame is taken from one snapshot of the synchronised inputs, so the digits never tear.
module sum_display_7seg #(
  parameter int unsigned DIGIT_TICKS     = 100_000,
  parameter int unsigned BLANK_TICKS     = 1_000,
  parameter bit          LEAD_ZERO_BLANK = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  sum_display_7seg_if.slave bus
);

  localparam int unsigned   CW        = $clog2(DIGIT_TICKS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_TICKS);

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_B    = 2'd2,
    SLOT_A    = 2'd3
  } slot_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
  } sample_t;

  sample_t       sync1, sync2, snap;
  logic [CW-1:0] cnt;
  slot_e         idx;
  logic          cnt_last;

  logic [1:0] tens;
  logic [3:0] ones;
  logic [3:0] nibble;
  logic       blank;
  logic [6:0] seg_d, seg_q;
  logic       dp_d, dp_q;
  logic [3:0] an_d, an_q;

  // Segment pattern {g..a}, active low.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction

  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    tens   = 2'd0;
    ones   = snap.sum[3:0];
    nibble = 4'h0;
    blank  = 1'b0;

    if (snap.sum >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(snap.sum - 5'd30);
    end else if (snap.sum >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(snap.sum - 5'd20);
    end else if (snap.sum >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(snap.sum - 5'd10);
    end

    case (idx)
      SLOT_ONES: nibble = ones;
      SLOT_TENS: begin
        nibble = {2'b00, tens};
        blank  = LEAD_ZERO_BLANK && (tens == 2'd0);
      end
      SLOT_B:    nibble = snap.b;
      SLOT_A:    nibble = snap.a;
    endcase

    seg_d = blank ? 7'h7F : hex7(nibble);
    dp_d  = (idx != SLOT_B);
    // All anodes stay off at the start of a slot so the previous digit cannot ghost.
    an_d  = (cnt < CNT_BLANK) ? 4'hF : ~(4'b0001 << idx);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      snap  <= '0;
      cnt   <= '0;
      idx   <= SLOT_ONES;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= 4'hF;
    end else begin
      sync1 <= {bus.a, bus.b, bus.sum};
      sync2 <= sync1;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      if (cnt_last) begin
        cnt <= '0;
        idx <= slot_e'(idx + 2'd1);
        // Latch a fresh snapshot only as the last slot of a frame ends.
        if (idx == SLOT_A) snap <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule
